selector_y: RTL and testbench

SELECTOR_Y -- requirements
Module: selector_y

---
 rtl/selector_y.sv | 125 ++++++++++++
 tb/tb_selector_y.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/selector_y.sv
// Row selector for a 3x3 board cursor.
// Synchronizes and debounces three buttons and drives the row/confirm FSM.
module selector_y #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_Y           = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_arriba,
    input  logic       btn_abajo,
    input  logic       btn_confirmar,
    input  logic       habilitar,
    output logic [2:0] valorY,
    output logic       listoY
);

    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] CNT_MAX = 8'hFF;
    localparam logic [2:0] TOP     = 3'(MAX_Y);

    localparam int ARR = 0;
    localparam int ABA = 1;
    localparam int CNF = 2;

    typedef enum logic [1:0] {
        ESPERA,
        MOVER,
        CONFIRMAR
    } state_t;

    state_t     state;
    logic [2:0] raw;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] level;
    logic [2:0] rise;
    logic [2:0] pend;
    logic [2:0] req;
    logic [7:0] cnt [3];
    logic [2:0] row_up;
    logic [2:0] row_down;

    assign raw = {btn_confirmar, btn_abajo, btn_arriba};
    assign req = rise | pend;

    // Up wraps from 0 to the top row; down wraps from the top row to 0.
    // Out-of-range values are folded back in so the row stays legal.
    assign row_up   = (valorY == 3'd0 || valorY > TOP) ? TOP
                                                      : valorY - 3'd1;
    assign row_down = (valorY >= TOP) ? 3'd0 : valorY + 3'd1;

    // Two-flop synchronizer for all raw button inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Per-button debouncer: count while the synchronized level disagrees
    // with the accepted level, flip after enough cycles, flag rising flips.
    always_ff @(posedge clk) begin
        if (reset) begin
            level <= '0;
            rise  <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            rise <= '0;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LAST) begin
                    level[i] <= sync2[i];
                    rise[i]  <= sync2[i];
                    cnt[i]   <= '0;
                end else if (cnt[i] != CNT_MAX) begin
                    cnt[i] <= cnt[i] + 8'd1;
                end
            end
        end
    end

    // Control FSM: the row update and listoY are registered on the edge
    // that leaves ESPERA; MOVER/CONFIRMAR hold late presses for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ESPERA;
            valorY <= 3'd0;
            listoY <= 1'b0;
            pend   <= '0;
        end else begin
            listoY <= 1'b0;
            unique case (state)
                ESPERA: begin
                    pend <= '0;
                    if (habilitar) begin
                        if (req[CNF]) begin
                            state  <= CONFIRMAR;
                            listoY <= 1'b1;
                        end else if (req[ARR] && !req[ABA]) begin
                            state  <= MOVER;
                            valorY <= row_up;
                        end else if (req[ABA] && !req[ARR]) begin
                            state  <= MOVER;
                            valorY <= row_down;
                        end
                    end
                end
                MOVER, CONFIRMAR: begin
                    pend  <= pend | rise;
                    state <= ESPERA;
                end
                default: begin
                    state <= ESPERA;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_selector_y.sv
// Scoreboard bench for selector_y.
// Expected row/confirm events are queued with stimulus and matched to observed ones.
module tb_selector_y;

    localparam int DB   = 4;
    localparam int MAXY = 2;

    typedef struct {
        bit       listo;
        logic [2:0] val;
        int       cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_arriba = 1'b0;
    logic       btn_abajo = 1'b0;
    logic       btn_confirmar = 1'b0;
    logic       habilitar = 1'b1;
    logic [2:0] valorY;
    logic       listoY;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   c;
    bit   over_seen = 0;
    logic [2:0] last = 3'd0;
    logic [2:0] mval = 3'd0;
    ev_t  exp_q[$];
    ev_t  obs_q[$];
    ev_t  o;
    ev_t  e;

    selector_y #(.DEBOUNCE_CYCLES(DB), .MAX_Y(MAXY)) dut (
        .clk(clk),
        .reset(reset),
        .btn_arriba(btn_arriba),
        .btn_abajo(btn_abajo),
        .btn_confirmar(btn_confirmar),
        .habilitar(habilitar),
        .valorY(valorY),
        .listoY(listoY)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe outputs mid-cycle: every listo pulse cycle and every row change.
    always @(negedge clk) begin
        if (valorY > 3'(MAXY)) over_seen = 1;
        if (reset) begin
            last = valorY;
        end else begin
            if (listoY) obs_q.push_back('{1'b1, valorY, cyc});
            if (valorY !== last) obs_q.push_back('{1'b0, valorY, cyc});
            last = valorY;
        end
    end

    function automatic logic [2:0] up(input logic [2:0] v);
        return (v == 3'd0) ? 3'(MAXY) : v - 3'd1;
    endfunction

    function automatic logic [2:0] dn(input logic [2:0] v);
        return (v == 3'(MAXY)) ? 3'd0 : v + 3'd1;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input logic [2:0] b);
        btn_arriba    = b[0];
        btn_abajo     = b[1];
        btn_confirmar = b[2];
    endtask

    task automatic start();
        exp_q.delete();
        obs_q.delete();
        c = cyc;
    endtask

    task automatic move(input logic [2:0] b, input logic [2:0] v);
        start();
        exp_q.push_back('{1'b0, v, c + 3 + DB});
        mval = v;
        set_btn(b);
        idle(8);
        set_btn(3'b000);
        idle(DB + 10);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        checks++;
        if (valorY !== 3'd0) begin
            errors++;
            $display("FAIL reset_val got %0d want 0", valorY);
        end
        checks++;
        if (listoY !== 1'b0) begin
            errors++;
            $display("FAIL reset_listo got %0b want 0", listoY);
        end
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_latency();
        start();
        exp_q.push_back('{1'b0, dn(mval), c + 3 + DB});
        mval = dn(mval);
        set_btn(3'b010);
        idle(10);
        set_btn(3'b000);
        idle(DB + 10);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL latency_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.listo !== e.listo || o.val !== e.val || o.cyc !== e.cyc) begin
                errors++;
                $display("FAIL latency_ev got l%0b v%0d c%0d want l%0b v%0d c%0d",
                         o.listo, o.val, o.cyc, e.listo, e.val, e.cyc);
            end
        end
    endtask

    task automatic test_wrap();
        logic [2:0] seq [4];
        logic [2:0] b;
        seq = '{3'b001, 3'b001, 3'b010, 3'b010};
        for (int i = 0; i < 4; i++) begin
            b = seq[i];
            move(b, b[0] ? up(mval) : dn(mval));
            checks++;
            if (obs_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL wrap_count%0d got %0d want %0d", i, obs_q.size(), exp_q.size());
            end
            while (obs_q.size() > 0 && exp_q.size() > 0) begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                checks++;
                if (o.listo !== e.listo || o.val !== e.val || o.cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL wrap_ev%0d got l%0b v%0d c%0d want l%0b v%0d c%0d",
                             i, o.listo, o.val, o.cyc, e.listo, e.val, e.cyc);
                end
            end
        end
    endtask

    task automatic test_bounce();
        start();
        set_btn(3'b010);
        idle(2);
        set_btn(3'b000);
        idle(1);
        set_btn(3'b010);
        idle(2);
        set_btn(3'b000);
        idle(DB + 10);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL bounce_events got %0d want 0", obs_q.size());
        end
        checks++;
        if (valorY !== mval) begin
            errors++;
            $display("FAIL bounce_val got %0d want %0d", valorY, mval);
        end
    endtask

    task automatic test_simultaneous();
        start();
        set_btn(3'b011);
        idle(10);
        set_btn(3'b000);
        idle(DB + 10);
        checks++;
        if (obs_q.size() != 0 || valorY !== mval) begin
            errors++;
            $display("FAIL cancel got n%0d v%0d want n0 v%0d", obs_q.size(), valorY, mval);
        end
        start();
        exp_q.push_back('{1'b1, mval, c + 3 + DB});
        set_btn(3'b110);
        idle(10);
        set_btn(3'b000);
        idle(DB + 10);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL prio_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.listo !== e.listo || o.val !== e.val || o.cyc !== e.cyc) begin
                errors++;
                $display("FAIL prio_ev got l%0b v%0d c%0d want l%0b v%0d c%0d",
                         o.listo, o.val, o.cyc, e.listo, e.val, e.cyc);
            end
        end
    endtask

    task automatic test_enable();
        start();
        habilitar = 1'b0;
        set_btn(3'b010);
        idle(DB + 6);
        habilitar = 1'b1;
        idle(DB + 6);
        set_btn(3'b000);
        idle(DB + 10);
        checks++;
        if (obs_q.size() != 0 || valorY !== mval) begin
            errors++;
            $display("FAIL enable got n%0d v%0d want n0 v%0d", obs_q.size(), valorY, mval);
        end
    endtask

    task automatic test_back_to_back();
        start();
        exp_q.push_back('{1'b0, dn(mval), c + 3 + DB});
        exp_q.push_back('{1'b1, dn(mval), c + 5 + DB});
        mval = dn(mval);
        set_btn(3'b010);
        idle(1);
        set_btn(3'b110);
        idle(10);
        set_btn(3'b000);
        idle(DB + 10);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL pend_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.listo !== e.listo || o.val !== e.val || o.cyc !== e.cyc) begin
                errors++;
                $display("FAIL pend_ev got l%0b v%0d c%0d want l%0b v%0d c%0d",
                         o.listo, o.val, o.cyc, e.listo, e.val, e.cyc);
            end
        end
    endtask

    task automatic test_reset_abort();
        start();
        set_btn(3'b010);
        idle(2);
        reset = 1'b1;
        idle(2);
        set_btn(3'b000);
        idle(1);
        reset = 1'b0;
        mval = 3'd0;
        idle(DB + 10);
        checks++;
        if (valorY !== 3'd0 || listoY !== 1'b0) begin
            errors++;
            $display("FAIL abort_out got v%0d l%0b want v0 l0", valorY, listoY);
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL abort_events got %0d want 0", obs_q.size());
        end
    endtask

    task automatic test_reset_hold();
        set_btn(3'b010);
        reset = 1'b1;
        idle(3);
        start();
        reset = 1'b0;
        exp_q.push_back('{1'b0, dn(mval), c + 3 + DB});
        mval = dn(mval);
        idle(DB + 10);
        set_btn(3'b000);
        idle(DB + 10);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL hold_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.listo !== e.listo || o.val !== e.val || o.cyc !== e.cyc) begin
                errors++;
                $display("FAIL hold_ev got l%0b v%0d c%0d want l%0b v%0d c%0d",
                         o.listo, o.val, o.cyc, e.listo, e.val, e.cyc);
            end
        end
    endtask

    task automatic test_range();
        checks++;
        if (over_seen !== 1'b0) begin
            errors++;
            $display("FAIL range got over=%0b want 0", over_seen);
        end
        checks++;
        if (valorY !== mval) begin
            errors++;
            $display("FAIL final_val got %0d want %0d", valorY, mval);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_latency();
        test_wrap();
        test_bounce();
        test_simultaneous();
        test_enable();
        test_back_to_back();
        test_reset_abort();
        test_reset_hold();
        test_range();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
